// File: rtl/sram_port_driver.sv
// sram_port_driver: turns a valid/ready request stream into registered cycles on the
// single RW port of the SRAM macro, captures dout0 and returns read data in order on
// a valid/ready response stream.
// Build option SRAM_DRV_RESP_FIFO_EN: when defined, responses are held in a 3-entry
// circular FIFO; otherwise a single response register is used.
module sram_port_driver #(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0,
  output logic                  busy
);

`ifdef SRAM_DRV_RESP_FIFO_EN
  localparam int unsigned RESP_DEPTH = 3;
`else
  localparam int unsigned RESP_DEPTH = 1;
`endif
  localparam logic [2:0] DEPTH_W = 3'(RESP_DEPTH);

  logic                  r_req_ready;
  logic                  r_csb;
  logic                  r_web;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic                  r_rd_p1;   // read presented to the macro this cycle
  logic                  r_rd_p2;   // read sampled by the macro, dout0 valid at next edge
  logic [1:0]            r_count;   // buffered responses

  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_capture;
  logic                  w_pop;
  logic [1:0]            w_count_nxt;
  logic [2:0]            w_out_nxt;

  assign w_accept    = req_valid & r_req_ready;
  assign w_rd_accept = w_accept & ~req_we;
  assign w_capture   = r_rd_p2;
  assign w_pop       = (r_count != '0) & resp_ready;

  // Next buffer occupancy and next outstanding count (reads in flight + buffered)
  always_comb begin
    w_count_nxt = r_count;
    case ({w_capture, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
    w_out_nxt = {2'b00, w_rd_accept} + {2'b00, r_rd_p1} + {1'b0, w_count_nxt};
  end

  // Credit: req_ready is the registered image of next-cycle outstanding < depth,
  // so a pop at edge T can only raise it after T
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_req_ready <= 1'b0;
    end else begin
      r_req_ready <= (w_out_nxt < DEPTH_W);
    end
  end

  // Macro port registers; address/data hold on cycles without an accept
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_csb  <= 1'b1;
      r_web  <= 1'b1;
      r_addr <= '0;
      r_din  <= '0;
    end else begin
      r_csb <= ~w_accept;
      r_web <= ~(w_accept & req_we);
      if (w_accept) begin
        r_addr <= req_addr;
        r_din  <= req_wdata;
      end
    end
  end

  // Read pipeline tracking and response occupancy
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_rd_p1 <= 1'b0;
      r_rd_p2 <= 1'b0;
      r_count <= '0;
    end else begin
      r_rd_p1 <= w_rd_accept;
      r_rd_p2 <= r_rd_p1;
      r_count <= w_count_nxt;
    end
  end

`ifdef SRAM_DRV_RESP_FIFO_EN
  localparam logic [1:0] LAST_IDX = 2'(RESP_DEPTH - 1);

  logic [DATA_WIDTH-1:0] r_mem [RESP_DEPTH];
  logic [1:0]            r_wr_ptr;
  logic [1:0]            r_rd_ptr;

  // Circular response FIFO; capture and pop on the same edge touch different entries
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_capture) begin
        r_mem[r_wr_ptr] <= dout0;
        r_wr_ptr        <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 2'd1;
      end
    end
  end

  assign resp_rdata = r_mem[r_rd_ptr];
`else
  logic [DATA_WIDTH-1:0] r_rdata;

  // Single response register; the credit rule guarantees it is empty when a read lands
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      r_rdata <= '0;
    end else if (w_capture) begin
      r_rdata <= dout0;
    end
  end

  assign resp_rdata = r_rdata;
`endif

  assign req_ready  = r_req_ready;
  assign csb0       = r_csb;
  assign web0       = r_web;
  assign addr0      = r_addr;
  assign din0       = r_din;
  assign resp_valid = (r_count != '0);
  assign busy       = r_rd_p1 | r_rd_p2 | (r_count != '0);

endmodule

// File: tb/tb_sram_port_driver.sv
// tb_sram_port_driver: drives sram_port_driver against a behavioural SRAM macro and
// checks every cycle against a queue-based transaction model.
module tb_sram_port_driver;

`ifdef SRAM_DRV_RESP_FIFO_EN
  localparam int DEPTH = 3;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk0 = 1'b0;
  logic       rst0_n;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [1:0] req_wdata;
  logic       resp_valid, resp_ready;
  logic [1:0] resp_rdata;
  logic       csb0, web0;
  logic [3:0] addr0;
  logic [1:0] din0, dout0;
  logic       busy;

  sram_port_driver #(.DATA_WIDTH(2), .ADDR_WIDTH(4)) dut (
    .clk0(clk0), .rst0_n(rst0_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .csb0(csb0), .web0(web0), .addr0(addr0), .din0(din0), .dout0(dout0),
    .busy(busy)
  );

  always #5 clk0 = ~clk0;

  // Behavioural macro: samples its port at posedge, drives dout0 shortly after the
  // following negedge.
  logic [1:0] sram [16];
  logic       mac_cs, mac_we;
  logic [3:0] mac_a;
  logic [1:0] mac_d, mac_rd;
  bit         mac_pend;

  always @(negedge clk0) begin
    mac_cs = !csb0; mac_we = !web0; mac_a = addr0; mac_d = din0;
    if (mac_pend) begin
      mac_pend = 1'b0;
      #1 dout0 = mac_rd;
    end
  end

  always @(posedge clk0) begin
    if (mac_cs) begin
      if (mac_we) sram[mac_a] = mac_d;
      else begin mac_rd = sram[mac_a]; mac_pend = 1'b1; end
    end
    mac_cs = 1'b0;
  end

  // Transaction model
  typedef struct { int due; logic [1:0] data; } fl_t;
  fl_t        m_fl[$];
  logic [1:0] m_resp[$];
  logic [1:0] m_mem [16];
  bit         m_ready, m_csb, m_web;
  logic [3:0] m_addr;
  logic [1:0] m_din;
  int         edge_n = 0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fl.delete(); m_resp.delete();
    m_ready = 1'b0; m_csb = 1'b1; m_web = 1'b1; m_addr = '0; m_din = '0;
  endtask

  task automatic model_edge(input bit v, input bit we, input logic [3:0] a,
                            input logic [1:0] d, input bit rr, output bit acc);
    fl_t e;
    acc = v && m_ready;
    if (m_resp.size() != 0 && rr) void'(m_resp.pop_front());
    while (m_fl.size() != 0 && m_fl[0].due == edge_n) begin
      m_resp.push_back(m_fl[0].data);
      void'(m_fl.pop_front());
    end
    if (acc) begin
      if (we) m_mem[a] = d;
      else begin e.due = edge_n + 2; e.data = m_mem[a]; m_fl.push_back(e); end
      m_addr = a; m_din = d;
    end
    m_csb   = !acc;
    m_web   = !(acc && we);
    m_ready = (m_fl.size() + m_resp.size()) < DEPTH;
    edge_n++;
  endtask

  task automatic check_outputs();
    check_eq("req_ready", req_ready, m_ready);
    check_eq("resp_valid", resp_valid, m_resp.size() != 0);
    if (m_resp.size() != 0) check_eq("resp_rdata", resp_rdata, m_resp[0]);
    check_eq("busy", busy, (m_fl.size() + m_resp.size()) != 0);
    check_eq("csb0", csb0, m_csb);
    check_eq("web0", web0, m_web);
    check_eq("addr0", addr0, m_addr);
    check_eq("din0", din0, m_din);
  endtask

  task automatic run_cycle(input bit v, input bit we, input logic [3:0] a,
                           input logic [1:0] d, input bit rr, output bit acc);
    req_valid = v; req_we = we; req_addr = a; req_wdata = d; resp_ready = rr;
    @(posedge clk0);
    model_edge(v, we, a, d, rr, acc);
    @(negedge clk0);
    check_outputs();
  endtask

  task automatic send_req(input bit we, input logic [3:0] a, input logic [1:0] d, input bit rr);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 16 && !acc; t++) run_cycle(1'b1, we, a, d, rr, acc);
    check_eq("req_accept", acc, 1);
  endtask

  task automatic drain();
    bit acc;
    for (int k = 0; k < 32 && (m_fl.size() + m_resp.size()) != 0; k++)
      run_cycle(1'b0, 1'b0, 4'h0, 2'h0, 1'b1, acc);
    check_eq("drain_busy", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit acc;
    rst0_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b0; dout0 = '0; mac_pend = 1'b0; mac_cs = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sram[i]  = 2'(i * 3);
      m_mem[i] = 2'(i * 3);
    end
    model_reset();

    // Reset values
    repeat (2) @(negedge clk0);
    check_eq("rst_csb0", csb0, 1);
    check_eq("rst_web0", web0, 1);
    check_eq("rst_addr0", addr0, 0);
    check_eq("rst_din0", din0, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_rdata", resp_rdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_req_ready", req_ready, 0);
    #2 rst0_n = 1'b1;
    run_cycle(1'b0, 1'b0, 4'h0, 2'h0, 1'b1, acc);
    check_eq("rel_req_ready", req_ready, 1);
    check_eq("rel_csb0", csb0, 1);

    // Write then read of the same address, exact 2-cycle latency
    send_req(1'b1, 4'h5, 2'b10, 1'b0);
    send_req(1'b0, 4'h5, 2'b00, 1'b0);
    run_cycle(1'b0, 1'b0, 4'h0, 2'h0, 1'b0, acc);
    check_eq("lat1_valid", resp_valid, 0);
    run_cycle(1'b0, 1'b0, 4'h0, 2'h0, 1'b0, acc);
    check_eq("lat2_valid", resp_valid, 1);
    check_eq("lat2_data", resp_rdata, 2'b10);
    drain();

    // Fill all addresses, stream reads back with resp_ready high
    for (int a = 0; a < 16; a++) send_req(1'b1, 4'(a), 2'(a), 1'b1);
    for (int a = 0; a < 16; a++) send_req(1'b0, 4'(a), 2'b00, 1'b1);
    drain();

    // Backpressure: reads queued against a stalled consumer
    for (int k = 0; k < DEPTH + 3; k++) run_cycle(1'b1, 1'b0, 4'((k * 5) % 16), 2'h0, 1'b0, acc);
    check_eq("bp_req_ready", req_ready, 0);
    repeat (3) run_cycle(1'b0, 1'b0, 4'h0, 2'h0, 1'b0, acc);
    drain();

    // Random mixed traffic with idle gaps and random backpressure
    for (int k = 0; k < 400; k++)
      run_cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0, acc);
    drain();

    // Reset with reads in flight
    run_cycle(1'b1, 1'b0, 4'h2, 2'h0, 1'b0, acc);
    run_cycle(1'b1, 1'b0, 4'h9, 2'h0, 1'b0, acc);
    #1 rst0_n = 1'b0;
    req_valid = 1'b0; resp_ready = 1'b0;
    #1;
    check_eq("arst_csb0", csb0, 1);
    check_eq("arst_resp_valid", resp_valid, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_req_ready", req_ready, 0);
    repeat (2) @(negedge clk0);
    #2 rst0_n = 1'b1;
    model_reset();
    repeat (6) run_cycle(1'b0, 1'b0, 4'h0, 2'h0, 1'b1, acc);

    // Macro contents must match every accepted write and nothing else
    for (int a = 0; a < 16; a++) check_eq("sram_content", sram[a], m_mem[a]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
